// File: rtl/sad_pe_array_p_if.sv
// sad_pe_array_p_if -- bus bundle for the SAD processing-element array.
//   master : block driver (start, current rows, reference beats, flush)
//   slave  : the array (ready/busy, per-PE abs values, SAD, best match)
// Widths follow the array parameters; SW = PIXEL + clog2(ROWS*COLS).
interface sad_pe_array_p_if #(
   parameter int PIXEL     = 8,
   parameter int COLS      = 16,
   parameter int ROWS      = 16,
   parameter int LOAD_ROWS = 4,
   parameter int SW        = PIXEL + $clog2(ROWS*COLS)
);
   logic                             start;
   logic [COLS*PIXEL-1:0]            cur_in;
   logic                             cur_valid;
   logic                             cur_ready;
   logic [LOAD_ROWS*COLS*PIXEL-1:0]  ref_in;
   logic                             ref_valid;
   logic                             ref_mode;
   logic                             ref_flush;
   logic                             busy;
   logic [ROWS*COLS*PIXEL-1:0]       abs_outs;
   logic [SW-1:0]                    sad_out;
   logic                             sad_valid;
   logic [SW-1:0]                    best_sad;
   logic [15:0]                      best_idx;

   modport master (
      output start, cur_in, cur_valid, ref_in, ref_valid, ref_mode, ref_flush,
      input  cur_ready, busy, abs_outs, sad_out, sad_valid, best_sad, best_idx
   );

   modport slave (
      input  start, cur_in, cur_valid, ref_in, ref_valid, ref_mode, ref_flush,
      output cur_ready, busy, abs_outs, sad_out, sad_valid, best_sad, best_idx
   );
endinterface

// File: rtl/sad_pe_array_p.sv
// sad_pe_array_p -- ROWS x COLS sum-of-absolute-differences array.
// A current block is loaded row by row (cur_in, ROWS beats); a reference
// window shifts upward by 1 or LOAD_ROWS rows per ref beat. Every cycle each
// PE registers |cur-ref|, rows are summed, then the block SAD is registered.
// A ref beat accepted in SEARCH that leaves the window full yields one
// sad_valid pulse three edges later.
// Ports: clk, rst_n (synchronous, active low), io (sad_pe_array_p_if.slave).
// Optional feature: define SAD_MIN_TRACK_EN to build the running-minimum
// tracker (best_sad/best_idx); otherwise both outputs are tied to zero.

// Single PE: registered absolute difference.
module sad_pe #(
   parameter int PIXEL = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PIXEL-1:0] a,
   input  logic [PIXEL-1:0] b,
   output logic [PIXEL-1:0] abs_q
);
   always_ff @(posedge clk) begin
      if (!rst_n) abs_q <= '0;
      else        abs_q <= (a > b) ? a - b : b - a;
   end
endmodule

module sad_pe_array_p #(
   parameter int PIXEL     = 8,
   parameter int COLS      = 16,
   parameter int ROWS      = 16,
   parameter int LOAD_ROWS = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   sad_pe_array_p_if.slave io
);
   localparam int SW     = PIXEL + $clog2(ROWS*COLS);
   localparam int CW     = $clog2(ROWS+1);
   localparam int STAGES = 3;

   typedef logic [COLS-1:0][PIXEL-1:0] row_t;
   typedef enum logic [1:0] {IDLE, LOAD_CUR, SEARCH} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   row_cnt, row_cnt_nxt;
   logic [CW-1:0]   fill, fill_upd;
   row_t [ROWS-1:0] cur_q, ref_q, cur_sh, ref_sh1, ref_shl, abs_q;
   row_t [LOAD_ROWS-1:0] ref_rows;
   logic            cur_acc, ref_acc, tag;
   logic [STAGES:0] vld_pipe;
   logic [ROWS-1:0][SW-1:0] row_sum_d, row_sum_q;
   logic [SW-1:0]   sad_d, sad_q;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         row_cnt <= '0;
      end else begin
         state   <= state_nxt;
         row_cnt <= row_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      row_cnt_nxt = row_cnt;
      case (state)
         IDLE: if (io.start) begin
            state_nxt   = LOAD_CUR;
            row_cnt_nxt = '0;
         end
         LOAD_CUR: begin
            if (io.start) row_cnt_nxt = '0;   // restart the load in place
            else if (io.cur_valid) begin
               if (row_cnt == CW'(ROWS-1)) begin
                  state_nxt   = SEARCH;
                  row_cnt_nxt = '0;
               end else begin
                  row_cnt_nxt = row_cnt + CW'(1);
               end
            end
         end
         SEARCH: if (io.start) begin
            state_nxt   = LOAD_CUR;
            row_cnt_nxt = '0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign cur_acc      = io.cur_valid && (state == LOAD_CUR) && !io.start;
   assign ref_acc      = io.ref_valid && !io.ref_flush;
   assign io.busy      = (state != IDLE);
   assign io.cur_ready = (state == LOAD_CUR);

   // ---------------- pixel registers ----------------
   // Row ROWS-1 is the entry point; data moves toward row 0.
   assign ref_rows = io.ref_in;
   assign cur_sh   = {io.cur_in, cur_q[ROWS-1:1]};
   assign ref_sh1  = {ref_rows[0], ref_q[ROWS-1:1]};
   generate
      if (ROWS == LOAD_ROWS) begin : g_shl_full
         assign ref_shl = ref_rows;
      end else begin : g_shl_part
         assign ref_shl = {ref_rows, ref_q[ROWS-1:LOAD_ROWS]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_q <= '0;
         ref_q <= '0;
      end else begin
         if (cur_acc) cur_q <= cur_sh;
         if (ref_acc) ref_q <= io.ref_mode ? ref_shl : ref_sh1;
      end
   end

   // ---------------- window fill count ----------------
   always_comb begin
      fill_upd = fill;
      if (ref_acc) begin
         if (!io.ref_mode)
            fill_upd = (fill >= CW'(ROWS-1)) ? CW'(ROWS) : fill + CW'(1);
         else
            fill_upd = (fill >= CW'(ROWS-LOAD_ROWS)) ? CW'(ROWS) : fill + CW'(LOAD_ROWS);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)          fill <= '0;
      else if (io.ref_flush) fill <= '0;
      else                 fill <= fill_upd;
   end

   // ---------------- valid tag pipeline ----------------
   // vld_pipe[0..2] track E0..E2; vld_pipe[3] is the registered sad_valid.
   assign tag = ref_acc && (state == SEARCH) && (fill_upd == CW'(ROWS));

   always_ff @(posedge clk) begin
      if (!rst_n)        vld_pipe <= '0;
      else if (io.start) vld_pipe <= '0;   // drop beats from the old block
      else               vld_pipe <= {vld_pipe[STAGES-1:0], tag};
   end

   assign io.sad_valid = vld_pipe[STAGES];

   // ---------------- PE array ----------------
   generate
      for (genvar r = 0; r < ROWS; r++) begin : g_row
         for (genvar c = 0; c < COLS; c++) begin : g_col
            sad_pe #(.PIXEL(PIXEL)) u_pe (
               .clk   (clk),
               .rst_n (rst_n),
               .a     (cur_q[r][c]),
               .b     (ref_q[r][c]),
               .abs_q (abs_q[r][c])
            );
         end
      end
   endgenerate

   assign io.abs_outs = abs_q;

   // ---------------- adder stages ----------------
   always_comb begin
      row_sum_d = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            row_sum_d[r] = row_sum_d[r] + SW'(abs_q[r][c]);
   end

   always_comb begin
      sad_d = '0;
      for (int r = 0; r < ROWS; r++)
         sad_d = sad_d + row_sum_q[r];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_sum_q <= '0;
         sad_q     <= '0;
      end else begin
         row_sum_q <= row_sum_d;
         sad_q     <= sad_d;
      end
   end

   assign io.sad_out = sad_q;

   // ---------------- running minimum ----------------
`ifdef SAD_MIN_TRACK_EN
   logic [SW-1:0] best_q;
   logic [15:0]   best_idx_q, sad_cnt;
   logic          enter_search;

   assign enter_search = (state == LOAD_CUR) && (state_nxt == SEARCH);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         best_q     <= '1;
         best_idx_q <= '0;
         sad_cnt    <= '0;
      end else if (enter_search) begin
         best_q  <= '1;
         sad_cnt <= '0;
      end else if (vld_pipe[STAGES]) begin
         sad_cnt <= sad_cnt + 16'd1;
         // strict compare: ties keep the earlier index
         if (sad_q < best_q) begin
            best_q     <= sad_q;
            best_idx_q <= sad_cnt;
         end
      end
   end

   assign io.best_sad = best_q;
   assign io.best_idx = best_idx_q;
`else
   assign io.best_sad = '0;
   assign io.best_idx = '0;
`endif
endmodule

// File: tb/tb_sad_pe_array_p.sv
// tb_sad_pe_array_p -- directed, table-driven bench for sad_pe_array_p
// (default parameters). Expected values are hand-computed constants.
module tb_sad_pe_array_p;
   localparam int PIXEL = 8, COLS = 16, ROWS = 16, LOAD_ROWS = 4;
   localparam int BW = LOAD_ROWS*COLS*PIXEL;
`ifdef SAD_MIN_TRACK_EN
   localparam bit          TRK      = 1'b1;
   localparam logic [15:0] RST_BEST = 16'hFFFF;
`else
   localparam bit          TRK      = 1'b0;
   localparam logic [15:0] RST_BEST = 16'h0000;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sad_pe_array_p_if #(.PIXEL(PIXEL), .COLS(COLS), .ROWS(ROWS), .LOAD_ROWS(LOAD_ROWS)) bus ();

   sad_pe_array_p #(.PIXEL(PIXEL), .COLS(COLS), .ROWS(ROWS), .LOAD_ROWS(LOAD_ROWS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus)
   );

   typedef struct {
      logic [7:0]  cur_pix;
      logic [7:0]  ref_pix;
      logic [7:0]  exp_abs;
      logic [15:0] exp_sad;
   } vec_t;

   vec_t vecs [6];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [BW-1:0] uni(input logic [7:0] v);
      return {(LOAD_ROWS*COLS){v}};
   endfunction

   // 88 window pixels differ by 3 from cur=10, the other 168 by 2 -> SAD 600
   function automatic logic [BW-1:0] mix_beat(input int b);
      logic [BW-1:0] d;
      d = '0;
      for (int k = 0; k < LOAD_ROWS; k++)
         for (int c = 0; c < COLS; c++)
            d[(k*COLS+c)*PIXEL +: PIXEL] = (((b*LOAD_ROWS+k)*COLS+c) < 88) ? 8'd7 : 8'd8;
      return d;
   endfunction

   function automatic int count_bad(input logic [7:0] e);
      int n = 0;
      for (int p = 0; p < ROWS*COLS; p++)
         if (bus.abs_outs[p*PIXEL +: PIXEL] !== e) n++;
      return n;
   endfunction

   task automatic do_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic load_cur(input logic [7:0] v);
      bus.cur_in    = {COLS{v}};
      bus.cur_valid = 1'b1;
      repeat (ROWS) tick();
      bus.cur_valid = 1'b0;
   endtask

   task automatic do_flush();
      bus.ref_flush = 1'b1;
      tick();
      bus.ref_flush = 1'b0;
   endtask

   task automatic ref_beat(input logic [BW-1:0] d, input logic mode);
      bus.ref_in    = d;
      bus.ref_mode  = mode;
      bus.ref_valid = 1'b1;
      tick();
      bus.ref_valid = 1'b0;
   endtask

   // Five samples after the last beat's edge E0: index j is just after E(j).
   task automatic watch5(input logic [7:0] exp_abs, output logic [4:0] vh,
                         output logic [15:0] sad3, output int bad);
      vh = '0; sad3 = '0; bad = 0;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         vh[j] = bus.sad_valid;
         if (j == 1) bad = count_bad(exp_abs);
         if (j == 3) sad3 = bus.sad_out;
      end
   endtask

   initial begin
      logic [4:0]  vh;
      logic [15:0] s3, s18, s22;
      logic [23:0] hist;
      logic [15:0] wsad [4];
      int          bad;

      vecs[0] = '{8'd10,  8'd7,   8'd3,   16'd768};
      vecs[1] = '{8'd255, 8'd0,   8'd255, 16'd65280};
      vecs[2] = '{8'd0,   8'd255, 8'd255, 16'd65280};
      vecs[3] = '{8'd5,   8'd5,   8'd0,   16'd0};
      vecs[4] = '{8'd7,   8'd10,  8'd3,   16'd768};
      vecs[5] = '{8'd100, 8'd36,  8'd64,  16'd16384};

      rst_n = 1'b0;
      bus.start = 0; bus.cur_in = '0; bus.cur_valid = 0; bus.ref_in = '0;
      bus.ref_valid = 0; bus.ref_mode = 0; bus.ref_flush = 0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",      bus.busy, 0);
      chk("rst_cur_ready", bus.cur_ready, 0);
      chk("rst_sad_valid", bus.sad_valid, 0);
      chk("rst_sad_out",   bus.sad_out, 0);
      chk("rst_abs_bad",   count_bad(8'd0), 0);
      chk("rst_best_sad",  bus.best_sad, RST_BEST);
      chk("rst_best_idx",  bus.best_idx, 0);
      rst_n = 1'b1;

      // table: load block, fill window with 4 mode-1 beats, one SAD
      for (int i = 0; i < 6; i++) begin
         do_start();
         chk("vec_cur_ready", bus.cur_ready, 1);
         load_cur(vecs[i].cur_pix);
         do_flush();
         repeat (4) ref_beat(uni(vecs[i].ref_pix), 1'b1);
         watch5(vecs[i].exp_abs, vh, s3, bad);
         chk("vec_valid_timing", vh, 5'b01000);
         chk("vec_sad_out", s3, vecs[i].exp_sad);
         chk("vec_abs_bad", bad, 0);
         chk("vec_best_sad", bus.best_sad, TRK ? vecs[i].exp_sad : 16'd0);
         chk("vec_best_idx", bus.best_idx, 0);
      end

      // mode 0 fill: beats 1-15 untagged, 16..20 tagged back-to-back
      do_start();
      load_cur(8'd10);
      do_flush();
      hist = '0; s18 = '0; s22 = '0;
      for (int i = 0; i < 24; i++) begin
         bus.ref_in    = uni(8'd7);
         bus.ref_mode  = 1'b0;
         bus.ref_valid = (i < 20);
         tick();
         @(negedge clk);
         hist[i] = bus.sad_valid;
         if (i == 18) s18 = bus.sad_out;
         if (i == 22) s22 = bus.sad_out;
      end
      bus.ref_valid = 1'b0;
      chk("m0_valid_pattern", hist, 24'h7C0000);
      chk("m0_sad_first", s18, 16'd768);
      chk("m0_sad_last",  s22, 16'd768);

      // start right after a tagged beat kills its SAD
      ref_beat(uni(8'd7), 1'b0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      watch5(8'd3, vh, s3, bad);
      chk("kill_no_valid", vh, 5'b00000);
      chk("kill_busy", bus.busy, 1);
      chk("kill_cur_ready", bus.cur_ready, 1);

      // running minimum over windows 768, 512, 600, 512
      do_start();
      load_cur(8'd10);
      for (int w = 0; w < 4; w++) begin
         do_flush();
         for (int b = 0; b < 4; b++)
            ref_beat((w == 2) ? mix_beat(b) : uni((w == 0) ? 8'd7 : 8'd8), 1'b1);
         watch5((w == 0) ? 8'd3 : 8'd2, vh, s3, bad);
         wsad[w] = s3;
         chk("min_valid_timing", vh, 5'b01000);
      end
      chk("min_sad0", wsad[0], 16'd768);
      chk("min_sad1", wsad[1], 16'd512);
      chk("min_sad2", wsad[2], 16'd600);
      chk("min_sad3", wsad[3], 16'd512);
      chk("min_best_sad", bus.best_sad, TRK ? 16'd512 : 16'd0);
      chk("min_best_idx", bus.best_idx, TRK ? 16'd1 : 16'd0);

      // reset mid-search discards everything
      bus.ref_in = uni(8'd9); bus.ref_mode = 1'b1; bus.ref_valid = 1'b1;
      tick();
      bus.ref_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      chk("mid_rst_busy",     bus.busy, 0);
      chk("mid_rst_sad_out",  bus.sad_out, 0);
      chk("mid_rst_valid",    bus.sad_valid, 0);
      chk("mid_rst_best_sad", bus.best_sad, RST_BEST);
      rst_n = 1'b1;
      repeat (4) ref_beat(uni(8'd7), 1'b1);
      watch5(8'd7, vh, s3, bad);
      chk("post_rst_no_valid", vh, 5'b00000);
      chk("post_rst_abs_bad", bad, 0);
      chk("post_rst_busy", bus.busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sad_pe_array_p.md
SAD_PE_ARRAY_P -- requirements
Module: sad_pe_array_p

Interface
REQ-001 Parameter PIXEL, default 8: bits per pixel.
REQ-002 Parameter COLS, default 16: array columns.
REQ-003 Parameter ROWS, default 16: array rows. ROWS SHALL be a multiple of LOAD_ROWS.
REQ-004 Parameter LOAD_ROWS, default 4: reference rows per fast beat.
REQ-005 Derived width SW = PIXEL + clog2(ROWS*COLS); default SW = 16.
REQ-006 Ports:
- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  begin loading a new current block.
- cur_in  in  COLS*PIXEL  one current-block row; column c at bits [c*PIXEL +: PIXEL].
- cur_valid  in  1  current-row beat.
- cur_ready  out  1  high only in LOAD_CUR.
- ref_in  in  LOAD_ROWS*COLS*PIXEL  reference rows; row k at [k*COLS*PIXEL +: COLS*PIXEL].
- ref_valid  in  1  reference beat.
- ref_mode  in  1  0 = shift window by 1 row (ref_in row 0 only); 1 = shift by LOAD_ROWS rows.
- ref_flush  in  1  marks the reference window empty.
- busy  out  1  state != IDLE.
- abs_outs  out  ROWS*COLS*PIXEL  registered |cur-ref| per PE; PE (r,c) at [(r*COLS+c)*PIXEL +: PIXEL].
- sad_out  out  SW  block SAD.
- sad_valid  out  1  one-cycle qualifier for sad_out.
- best_sad  out  SW  running minimum SAD.
- best_idx  out  16  index of the minimum.

Function
REQ-010 FSM states: IDLE, LOAD_CUR, SEARCH.
- IDLE -> LOAD_CUR on start.
- LOAD_CUR -> SEARCH after the ROWS-th accepted cur beat.
- SEARCH -> LOAD_CUR on start.
- LOAD_CUR on start: row counter cleared, stay in LOAD_CUR.
REQ-011 Current beat accepted only when cur_valid && state==LOAD_CUR && !start. Accept: row ROWS-1 <= cur_in, row r <= row r+1 (data moves upward). cur_valid is ignored in other states.
REQ-012 Reference beat accepted in any state when ref_valid && !ref_flush.
- Mode 0: row ROWS-1 <= ref_in row 0, row r <= row r+1.
- Mode 1: row ROWS-LOAD_ROWS+k <= ref_in row k, row r <= row r+LOAD_ROWS.
REQ-013 Fill counter counts valid reference rows: +1 (mode 0) or +LOAD_ROWS (mode 1), saturating at ROWS. ref_flush clears it to 0 and has priority over a simultaneous ref_valid.
REQ-014 Pipeline, counting from edge E0 (the edge that samples an accepted reference beat):
- abs_outs registered at E1.
- Per-row sums registered at E2.
- sad_out registered at E3.
- sad_valid high for the one cycle following E3.
REQ-015 A beat is tagged valid iff state==SEARCH and the post-update fill count == ROWS. sad_valid is asserted only for tagged beats.
REQ-016 start clears all in-flight valid tags: no sad_valid for beats accepted before start. Data registers are unaffected.
REQ-017 abs_outs updates every cycle from the current cur/ref registers, whether or not a beat is tagged.
REQ-018 Unsigned arithmetic; abs is exact in PIXEL bits; sums are zero-extended and SHALL never overflow SW.
REQ-019 Back-to-back ref beats every cycle SHALL be sustained with throughput 1 SAD per cycle.

Reset
REQ-020 rst_n low at a clk edge: FSM = IDLE, all counters 0, pixel registers 0, abs_outs 0, sad_out 0, sad_valid 0, valid tags 0, best_sad = all-ones, best_idx 0.
REQ-021 Reset mid-operation SHALL discard all state. No sad_valid until a full reload (ROWS cur beats plus a full window) completes.

Configuration
REQ-030 Macro SAD_MIN_TRACK_EN.
- Defined: on each sad_valid, best_sad/best_idx are updated if sad_out < best_sad (strict; ties keep the earlier index). best_idx = count of prior valid SADs since entering SEARCH. The count and best_sad are re-initialised (0 / all-ones) on entry to SEARCH.
- Undefined: best_sad and best_idx are tied to 0 and no tracking logic is built.

Verification (defaults)
REQ-040 Reset asserted 2 cycles -> all outputs 0 except best_sad=16'hFFFF; busy=0; cur_ready=0.
REQ-041 start, 16 cur beats of 10, then 4 ref beats mode 1 of 7 -> abs_outs all 3; sad_out=768 with a single sad_valid, 3 cycles after the 4th ref beat's edge.
REQ-042 Mode 0 ref beats -> no sad_valid for beats 1-15; sad_valid on beat 16 and on every later beat.
REQ-043 start asserted the cycle after a tagged ref beat -> no sad_valid for that beat; state=LOAD_CUR; cur_ready=1.
REQ-044 cur all 255, ref all 0 -> sad_out=65280, no overflow; swapped values give the same result.
REQ-045 With SAD_MIN_TRACK_EN, window SADs 768, 512, 600, 512 -> best_sad=512, best_idx=1. Without the macro -> both outputs 0.
